// File: rtl/paddle_motion_ctrl.sv
// -----------------------------------------------------------------------------
// paddle_motion_ctrl
//
// Multi-channel paddle position controller for the Pong display path. Each
// paddle has its own up/down button pair. The buttons are synchronised and
// debounced. Positions advance only on frame_tick. A per-paddle FSM
// (IDLE/HOLD/FAST) speeds up a paddle that is held in one direction. Every
// position is clamped to [0, max_pos].
//
// Optional feature macro: PADDLE_ACCEL_EN
//   defined   : after ACCEL_FRAMES same-direction frames a paddle enters FAST
//               and moves FAST_STEP per frame.
//   undefined : FAST is never entered, HOLD moves STEP indefinitely, and no
//               hold counter is built.
//
// Ports:
//   clk        in   system clock
//   reset      in   asynchronous, active-high reset
//   frame_tick in   one-clock strobe, once per video frame
//   btn_up     in   raw up/decrease buttons, one bit per paddle (async)
//   btn_dn     in   raw down/increase buttons, one bit per paddle (async)
//   max_pos    in   inclusive upper position limit, shared, quasi-static
//   pos        out  packed positions, paddle i at [i*COORD_W +: COORD_W]
//   moving     out  1 while paddle i is not in IDLE
// -----------------------------------------------------------------------------
module paddle_motion_ctrl #(
  parameter int NUM_PADDLES  = 2,
  parameter int COORD_W      = 10,
  parameter int STEP         = 1,
  parameter int FAST_STEP    = 4,
  parameter int ACCEL_FRAMES = 8,
  parameter int DB_CYCLES    = 4,
  parameter int INIT_POS     = 240
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           frame_tick,
  input  logic [NUM_PADDLES-1:0]         btn_up,
  input  logic [NUM_PADDLES-1:0]         btn_dn,
  input  logic [COORD_W-1:0]             max_pos,
  output logic [NUM_PADDLES*COORD_W-1:0] pos,
  output logic [NUM_PADDLES-1:0]         moving
);

  // Up buttons occupy the low half of the conditioned vector and down buttons
  // the high half.
  localparam int NB   = 2 * NUM_PADDLES;
  localparam int DB_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, HOLD, FAST} state_e;
  typedef enum logic [1:0] {DIR_NONE, DIR_UP, DIR_DN} dir_e;

  // A zero step or a zero debounce/accel count is not a meaningful
  // configuration.
  if (STEP < 1 || FAST_STEP < 1 || ACCEL_FRAMES < 1 || DB_CYCLES < 1) begin : g_param_check
    $error("paddle_motion_ctrl: STEP, FAST_STEP, ACCEL_FRAMES, DB_CYCLES must be >= 1");
  end

  // ---------------------------------------------------------------------------
  // Input conditioning: 2-flop synchroniser followed by a debounce counter
  // ---------------------------------------------------------------------------
  logic [NB-1:0]   raw;
  logic [NB-1:0]   sync1_q, sync2_q;
  logic [NB-1:0]   db_q, db_d;
  logic [DB_W-1:0] db_cnt_q [NB];
  logic [DB_W-1:0] db_cnt_d [NB];

  assign raw = {btn_dn, btn_up};

  // NOTE: every assignment in a clocked block is non-blocking, so all flops
  // sample their old values together on the edge and the order of the
  // statements does not matter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      db_q    <= '0;
      // NOTE: the counter array is a set of plain flops rather than a RAM, so
      // it is reset along with the rest of the state.
      for (int i = 0; i < NB; i++) db_cnt_q[i] <= '0;
    end else begin
      sync1_q  <= raw;
      sync2_q  <= sync1_q;
      db_q     <= db_d;
      db_cnt_q <= db_cnt_d;
    end
  end

  // The counter runs only while the synchronised level disagrees with the
  // accepted level. On the DB_CYCLES-th consecutive disagreeing clock, the new
  // level is accepted and the counter restarts.
  always_comb begin
    for (int i = 0; i < NB; i++) begin
      // NOTE: every output of a combinational block gets a default first. Any
      // path that skips an assignment would otherwise infer a latch.
      db_d[i]     = db_q[i];
      db_cnt_d[i] = '0;
      if (sync2_q[i] != db_q[i]) begin
        if (db_cnt_q[i] == DB_W'(DB_CYCLES - 1)) db_d[i] = sync2_q[i];
        else                                     db_cnt_d[i] = db_cnt_q[i] + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Per-paddle motion FSM and position datapath
  // ---------------------------------------------------------------------------
  state_e             state_q  [NUM_PADDLES];
  state_e             state_d  [NUM_PADDLES];
  dir_e               dir_q    [NUM_PADDLES];
  dir_e               dir_d    [NUM_PADDLES];
  dir_e               dir_now  [NUM_PADDLES];
  logic [COORD_W-1:0] pos_q    [NUM_PADDLES];
  logic [COORD_W-1:0] pos_d    [NUM_PADDLES];
  logic [COORD_W:0]   step_sz  [NUM_PADDLES];
  logic [COORD_W:0]   sum      [NUM_PADDLES];
  logic [NUM_PADDLES-1:0] moving_q, moving_d;

`ifdef PADDLE_ACCEL_EN
  localparam int HOLD_W = $clog2(ACCEL_FRAMES + 1);
  logic [HOLD_W-1:0] hold_q [NUM_PADDLES];
  logic [HOLD_W-1:0] hold_d [NUM_PADDLES];
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      moving_q <= '0;
      for (int i = 0; i < NUM_PADDLES; i++) begin
        state_q[i] <= IDLE;
        dir_q[i]   <= DIR_NONE;
        pos_q[i]   <= COORD_W'(INIT_POS);
`ifdef PADDLE_ACCEL_EN
        hold_q[i]  <= '0;
`endif
      end
    end else begin
      moving_q <= moving_d;
      state_q  <= state_d;
      dir_q    <= dir_d;
      pos_q    <= pos_d;
`ifdef PADDLE_ACCEL_EN
      hold_q   <= hold_d;
`endif
    end
  end

  always_comb begin
    moving_d = moving_q;
    for (int i = 0; i < NUM_PADDLES; i++) begin
      state_d[i] = state_q[i];
      dir_d[i]   = dir_q[i];
      pos_d[i]   = pos_q[i];
      step_sz[i] = '0;
      dir_now[i] = DIR_NONE;
`ifdef PADDLE_ACCEL_EN
      hold_d[i]  = hold_q[i];
`endif

      // Both buttons held cancel out to no direction.
      if (db_q[i] && !db_q[NUM_PADDLES+i])      dir_now[i] = DIR_UP;
      else if (!db_q[i] && db_q[NUM_PADDLES+i]) dir_now[i] = DIR_DN;

      if (frame_tick) begin
        if (dir_now[i] == DIR_NONE) begin
          state_d[i] = IDLE;
`ifdef PADDLE_ACCEL_EN
          hold_d[i]  = '0;
`endif
        end else if (state_q[i] == IDLE || dir_now[i] != dir_q[i]) begin
          // A fresh press or a reversal restarts at normal speed.
          state_d[i] = HOLD;
          dir_d[i]   = dir_now[i];
          step_sz[i] = (COORD_W+1)'(STEP);
`ifdef PADDLE_ACCEL_EN
          hold_d[i]  = HOLD_W'(1);
`endif
        end else if (state_q[i] == HOLD) begin
          step_sz[i] = (COORD_W+1)'(STEP);
`ifdef PADDLE_ACCEL_EN
          // The frame on which the count reaches ACCEL_FRAMES still moves at
          // STEP. FAST_STEP takes effect on the following frame.
          if (hold_q[i] != HOLD_W'(ACCEL_FRAMES)) hold_d[i] = hold_q[i] + 1'b1;
          if (hold_q[i] >= HOLD_W'(ACCEL_FRAMES - 1)) state_d[i] = FAST;
`endif
        end else begin
          step_sz[i] = (COORD_W+1)'(FAST_STEP);
        end

        // The sum is one bit wider so that an overflow past max_pos is seen
        // rather than wrapping.
        sum[i] = {1'b0, pos_q[i]} + step_sz[i];

        if (pos_q[i] > max_pos) begin
          pos_d[i] = max_pos;
        end else if (dir_now[i] == DIR_UP) begin
          pos_d[i] = ({1'b0, pos_q[i]} < step_sz[i]) ? '0
                   : pos_q[i] - step_sz[i][COORD_W-1:0];
        end else if (dir_now[i] == DIR_DN) begin
          pos_d[i] = (sum[i] > {1'b0, max_pos}) ? max_pos : sum[i][COORD_W-1:0];
        end

        moving_d[i] = (state_d[i] != IDLE);
      end else begin
        sum[i] = '0;
      end
    end
  end

  for (genvar g = 0; g < NUM_PADDLES; g++) begin : g_pack
    assign pos[g*COORD_W +: COORD_W] = pos_q[g];
  end
  assign moving = moving_q;

endmodule

// File: tb/tb_paddle_motion_ctrl.sv
// -----------------------------------------------------------------------------
// tb_paddle_motion_ctrl
//
// Scoreboard bench for paddle_motion_ctrl with the default parameters (two
// paddles, 10-bit coordinates). Each frame tick that the stimulus issues
// pushes the expected post-tick {pos0, pos1, moving}. A monitor pops one entry
// for every tick the DUT sees and compares it with the outputs 1 ns after the
// edge. Expected values follow the PADDLE_ACCEL_EN setting of the build.
// -----------------------------------------------------------------------------
module tb_paddle_motion_ctrl;

`ifdef PADDLE_ACCEL_EN
  localparam int SPD2    = 4;    // per-frame step once past 8 held frames
  localparam int CLAMP_N = 40;
`else
  localparam int SPD2    = 1;
  localparam int CLAMP_N = 150;
`endif

  logic        clk        = 1'b0;
  logic        reset      = 1'b1;
  logic        frame_tick = 1'b0;
  logic [1:0]  btn_up     = '0;
  logic [1:0]  btn_dn     = '0;
  logic [9:0]  max_pos    = 10'd480;
  logic [19:0] pos;
  logic [1:0]  moving;

  paddle_motion_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .frame_tick (frame_tick),
    .btn_up     (btn_up),
    .btn_dn     (btn_dn),
    .max_pos    (max_pos),
    .pos        (pos),
    .moving     (moving)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [9:0] p0;
    logic [9:0] p1;
    logic [1:0] mv;
    string      nm;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Position after k held frames starting from base: frames 1..8 move 1,
  // later frames move SPD2.
  function automatic logic [9:0] ramp(input int k, input int base);
    return 10'((k <= 8) ? base + k : base + 8 + SPD2 * (k - 8));
  endfunction

  function automatic logic [9:0] cap(input int v, input int lim);
    return 10'((v > lim) ? lim : v);
  endfunction

  task automatic push(input logic [9:0] e0, input logic [9:0] e1,
                      input logic [1:0] em, input string nm);
    exp_t e;
    e.p0 = e0; e.p1 = e1; e.mv = em; e.nm = nm;
    sb_q.push_back(e);
  endtask

  task automatic tick(input logic [9:0] e0, input logic [9:0] e1,
                      input logic [1:0] em, input string nm);
    @(negedge clk);
    frame_tick = 1'b1;
    push(e0, e1, em, nm);
    @(negedge clk);
    frame_tick = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: every tick the DUT samples has a registered result 1 ns later.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      if (frame_tick && !reset) begin
        #1;
        if (sb_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL scoreboard: tick seen with no expected entry");
        end else begin
          e = sb_q.pop_front();
          check({e.nm, " pos0"},   32'(pos[9:0]),   32'(e.p0));
          check({e.nm, " pos1"},   32'(pos[19:10]), 32'(e.p1));
          check({e.nm, " moving"}, 32'(moving),     32'(e.mv));
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] p2;
    logic [9:0] e;

    // Reset state, checked while reset is still asserted.
    idle(2);
    check("reset pos0",   32'(pos[9:0]),   32'd240);
    check("reset pos1",   32'(pos[19:10]), 32'd240);
    check("reset moving", 32'(moving),     32'd0);
    reset = 1'b0;
    idle(2);
    tick(240, 240, 2'b00, "idle tick a");
    tick(240, 240, 2'b00, "idle tick b");

    // Paddle 0 held down: ramps and then accelerates. Paddle 1 stays still.
    btn_dn[0] = 1'b1;
    idle(10);
    for (int k = 1; k <= 10; k++) tick(ramp(k, 240), 240, 2'b01, "ramp");
    p2 = ramp(10, 240);

    // Upper clamp: pinned at 398, then a limit of 400 is reached and held.
    max_pos = 10'd398;
    for (int k = 1; k <= CLAMP_N; k++) tick(cap(int'(p2) + SPD2 * k, 398), 240, 2'b01, "pin398");
    max_pos = 10'd400;
    e = 10'd398;
    for (int k = 0; k < 3; k++) begin
      e = cap(int'(e) + SPD2, 400);
      tick(e, 240, 2'b01, "pin400");
    end

    // Limit drops below the position with no button: forced to the new limit.
    btn_dn[0] = 1'b0;
    idle(10);
    max_pos = 10'd300;
    tick(300, 240, 2'b00, "force300");

    // Glitch: a 2-clock btn_up[1] pulse that overlaps a tick is ignored.
    idle(2);
    @(negedge clk);
    btn_up[1]  = 1'b1;
    frame_tick = 1'b1;
    push(300, 240, 2'b00, "glitch tick");
    @(negedge clk);
    frame_tick = 1'b0;
    @(negedge clk);
    btn_up[1]  = 1'b0;
    idle(10);
    tick(300, 240, 2'b00, "after glitch");

    // Both buttons on paddle 1 cancel out. Releasing down leaves UP.
    btn_up[1] = 1'b1;
    btn_dn[1] = 1'b1;
    idle(10);
    tick(300, 240, 2'b00, "both a");
    tick(300, 240, 2'b00, "both b");
    btn_dn[1] = 1'b0;
    idle(10);
    tick(300, 239, 2'b10, "up only a");
    tick(300, 238, 2'b10, "up only b");
    btn_up[1] = 1'b0;
    idle(10);
    tick(300, 238, 2'b00, "release p1");

    // Reset mid-motion while paddle 0 is moving fast.
    max_pos   = 10'd480;
    btn_dn[0] = 1'b1;
    idle(10);
    for (int k = 1; k <= 9; k++) tick(ramp(k, 300), 238, 2'b01, "pre-reset");
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("async reset pos0",   32'(pos[9:0]),   32'd240);
    check("async reset pos1",   32'(pos[19:10]), 32'd240);
    check("async reset moving", 32'(moving),     32'd0);
    @(negedge clk);
    reset = 1'b0;
    // The held button is re-qualified: the debounced level rises on the 6th
    // edge after release. The ticks on edges 2, 4 and 6 see no direction, and
    // the tick on edge 8 moves.
    tick(240, 240, 2'b00, "requal wait a");
    tick(240, 240, 2'b00, "requal wait b");
    tick(240, 240, 2'b00, "requal wait c");
    tick(241, 240, 2'b01, "requal move a");
    tick(242, 240, 2'b01, "requal move b");
    btn_dn[0] = 1'b0;

    idle(4);
    check("scoreboard drained", 32'(sb_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/paddle_motion_ctrl.md
Name: paddle_motion_ctrl

Overview:
Multi-channel paddle position controller for the Pong display path. Each of NUM_PADDLES paddles has its own up and down button. Buttons are synchronised and debounced, and positions advance once per frame strobe. A per-paddle state machine accelerates a paddle that is held in one direction, and every position is clamped to a runtime limit. The packed positions feed the object renderer and collision logic.

Parameters:
NUM_PADDLES, 2, number of independent paddle channels
COORD_W, 10, width of the position coordinate in bits
STEP, 1, pixels moved per frame in normal speed
FAST_STEP, 4, pixels moved per frame in fast speed (PADDLE_ACCEL_EN only)
ACCEL_FRAMES, 8, consecutive same-direction moving frames before fast speed
DB_CYCLES, 4, clocks a synchronised input must hold a new level before it is accepted
INIT_POS, 240, reset position of every paddle

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
frame_tick  in  1  one-clock strobe, once per video frame
btn_up  in  NUM_PADDLES  raw up/decrease buttons, asynchronous, one bit per paddle
btn_dn  in  NUM_PADDLES  raw down/increase buttons, asynchronous
max_pos  in  COORD_W  inclusive upper position limit, shared by all paddles, quasi-static
pos  out  NUM_PADDLES*COORD_W  packed positions; paddle i is at bits [i*COORD_W +: COORD_W]
moving  out  NUM_PADDLES  1 while paddle i is not in IDLE

Behaviour:
- Reset is asynchronous, active-high. Reset values:
  - pos fields = INIT_POS.
  - moving = 0.
  - All FSMs in IDLE; hold counters = 0.
  - Synchroniser flops, debounce counters and debounced levels = 0.
- Input conditioning, per button:
  - 2-flop synchroniser.
  - The debounce counter increments while the synchronised level differs from the debounced level, and clears when they match.
  - When the counter reaches DB_CYCLES-1 on a differing cycle, the debounced level takes the new value.
  - Net latency from a stable input edge to the debounced level = 2 + DB_CYCLES clocks.
  - A pulse shorter than DB_CYCLES synchronised clocks is ignored.
- Direction per paddle, from debounced levels:
  - UP when only up is high; DN when only down is high.
  - NONE when neither is high, or when both are high.
- All position and FSM updates occur only on clocks with frame_tick=1. Outputs are registered and visible the clock after the tick.
- FSM per paddle, states IDLE, HOLD, FAST, plus a latched direction:
  - dir=NONE: go to IDLE, hold_cnt=0, no move.
  - IDLE with dir!=NONE: go to HOLD, latch dir, hold_cnt=1, move STEP this tick.
  - HOLD or FAST where dir differs from the latched dir: treat as IDLE entry (HOLD, hold_cnt=1, move STEP in the new direction).
  - HOLD with the same dir: move STEP, hold_cnt++. When hold_cnt reaches ACCEL_FRAMES, go to FAST; FAST_STEP applies from the next tick.
  - FAST with the same dir: move FAST_STEP.
  - hold_cnt saturates; its width is clog2(ACCEL_FRAMES+1).
- Arithmetic is done in COORD_W+1 bits, with no wrap-around:
  - UP: new = (pos < step) ? 0 : pos - step.
  - DN: new = (pos + step > max_pos) ? max_pos : pos + step.
- Reaching a limit does not change the FSM state; the paddle stays pinned at the limit.
- If max_pos drops below a current pos, that paddle is forced to max_pos on the next frame_tick, regardless of direction or state. The FSM still updates normally.
- Channels are fully independent; simultaneous activity on all channels is legal.
- Reset asserted mid-motion returns every paddle to INIT_POS/IDLE immediately. Buttons already held are re-qualified through the debounce stage after release of reset.

Optional Feature:
PADDLE_ACCEL_EN
- Defined: the FAST state and FAST_STEP are implemented as described above.
- Undefined: FAST is never entered. HOLD moves STEP indefinitely, the hold counter is not synthesised, and FAST_STEP and ACCEL_FRAMES are unused.

Test Plan:
- Reset check: defaults, reset asserted -> every pos field = 240, moving = 0; remains so with frame_tick pulsing and no buttons pressed.
- Hold down on paddle 0, PADDLE_ACCEL_EN defined, max_pos = 480, press held well before ticks begin -> pos0 reads 241..248 after ticks 1..8, then 252, 256; paddle 1 stays at 240.
- Glitch rejection: 2-clock pulse on btn_up[1] overlapping a frame_tick -> pos1 stays at 240, moving[1] = 0.
- Upper clamp: paddle 0 in FAST at pos 398, max_pos = 400 -> next tick gives 400, following ticks give 400, moving = 1. Then drop max_pos to 300 with no buttons pressed -> 300 after the next tick.
- Both buttons on paddle 1 at pos 240 -> no motion, moving[1] = 0. Then release down only -> HOLD in UP direction, next tick pos1 = 239.
- Reset mid-motion: paddle 0 in FAST at 300, assert reset for 1 clock -> pos0 = 240 asynchronously, IDLE. With the button still held, motion resumes at STEP only after the debounce latency.
